// File: rtl/ram_port_pkg.sv
// Shared definitions for the ram_port memory responder: FSM encoding,
// request counter width and default parameter values.
package ram_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int CNT_W       = 4;
  localparam int D_WIDTH_DEF = 4;
  localparam int A_WIDTH_DEF = 8;
  localparam int LATENCY_DEF = 2;

  // Counter preload: BUSY lasts exactly lat cycles, counting down to zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/ram_port_array.sv
// Word storage for ram_port: synchronous write, registered synchronous read,
// asynchronous clear of every word and of the read register.
module ram_port_array #(
  parameter int w_width = 4,
  parameter int a_width = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               we,
  input  logic               re,
  input  logic [a_width-1:0] addr,
  input  logic [w_width-1:0] wdata,
  output logic [w_width-1:0] rdata
);

  localparam int DEPTH = 1 << a_width;

  logic [w_width-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_port.sv
// Single-ported multi-cycle memory responder with busy/odv handshake.
// Optional read parity checking is enabled by defining RAM_PORT_PARITY_EN.
module ram_port
  import ram_port_pkg::*;
#(
  parameter int d_width = D_WIDTH_DEF,
  parameter int a_width = A_WIDTH_DEF,
  parameter int latency = LATENCY_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [a_width-1:0] addr,
  input  logic [d_width-1:0] data_in,
  input  logic               rw,
  input  logic               ce,
  output logic [d_width-1:0] data_out,
  output logic               odv,
  output logic               busy
`ifdef RAM_PORT_PARITY_EN
  ,
  output logic               perr,
  input  logic               pinj
`endif
);

`ifdef RAM_PORT_PARITY_EN
  localparam int W_WIDTH = d_width + 1;
`else
  localparam int W_WIDTH = d_width;
`endif

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [a_width-1:0] addr_p0;
  logic [d_width-1:0] data_p0;
  logic               rw_p0;
  logic               accept, complete, we, re;
  logic [W_WIDTH-1:0] wdata, rdata;
`ifdef RAM_PORT_PARITY_EN
  logic               pinj_p0;
`endif

  // A new request is taken in IDLE or DONE; ce is ignored while BUSY.
  assign accept   = ce && (state != BUSY);
  assign complete = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = ce ? BUSY : IDLE;
      BUSY:       if (cnt == '0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BUSY);
    odv  = (state == DONE);
    we   = complete && !rw_p0;
    re   = complete && rw_p0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                              cnt <= '0;
    else if (accept)                      cnt <= cnt_load(latency);
    else if (state == BUSY && cnt != '0)  cnt <= cnt - 1'b1;
  end

  // Stage p0: request latch; only these copies are used after acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0 <= addr;
      data_p0 <= data_in;
      rw_p0   <= rw;
`ifdef RAM_PORT_PARITY_EN
      pinj_p0 <= pinj;
`endif
    end
  end

`ifdef RAM_PORT_PARITY_EN
  assign wdata = {(^data_p0) ^ pinj_p0, data_p0};
  assign perr  = odv && rw_p0 && (rdata[d_width] != (^rdata[d_width-1:0]));
`else
  assign wdata = data_p0;
`endif

  assign data_out = rdata[d_width-1:0];

  ram_port_array #(
    .w_width(W_WIDTH),
    .a_width(a_width)
  ) u_array (
    .clk  (clk),
    .clr  (clr),
    .we   (we),
    .re   (re),
    .addr (addr_p0),
    .wdata(wdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_ram_port.sv
// Self-checking bench for ram_port: vector table plus hand sequences, with a
// completion scoreboard on the latency-2 instance and timing sweeps at 1 and 15.
module tb_ram_port;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] addr = '0;
  logic [3:0] data_in = '0;
  logic       rw = 1'b0;
  logic       ce = 1'b0, ce1 = 1'b0, ce15 = 1'b0;
  logic [3:0] data_out, do1, do15;
  logic       odv, busy, odv1, busy1, odv15, busy15;
`ifdef RAM_PORT_PARITY_EN
  logic       pinj = 1'b0;
  logic       perr, perr1, perr15;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rd;
    logic [3:0] d;
    bit         pe;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit         rd;
    logic [7:0] a;
    logic [3:0] d;
    logic [3:0] exp_d;
  } vec_t;

  always #5 clk = ~clk;

  ram_port #(.d_width(4), .a_width(8), .latency(2)) dut (
    .clk(clk), .clr(clr), .addr(addr), .data_in(data_in), .rw(rw), .ce(ce),
    .data_out(data_out), .odv(odv), .busy(busy)
`ifdef RAM_PORT_PARITY_EN
    , .perr(perr), .pinj(pinj)
`endif
  );

  ram_port #(.d_width(4), .a_width(8), .latency(1)) dut1 (
    .clk(clk), .clr(clr), .addr(addr), .data_in(data_in), .rw(rw), .ce(ce1),
    .data_out(do1), .odv(odv1), .busy(busy1)
`ifdef RAM_PORT_PARITY_EN
    , .perr(perr1), .pinj(pinj)
`endif
  );

  ram_port #(.d_width(4), .a_width(8), .latency(15)) dut15 (
    .clk(clk), .clr(clr), .addr(addr), .data_in(data_in), .rw(rw), .ce(ce15),
    .data_out(do15), .odv(odv15), .busy(busy15)
`ifdef RAM_PORT_PARITY_EN
    , .perr(perr15), .pinj(pinj)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Completion monitor: every odv must match the oldest outstanding request.
  sb_t e;
  always @(negedge clk) begin
    if (odv === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_odv actual=1 required=0");
      end else begin
        e = sb.pop_front();
        if (e.rd) chk("rd_data", {28'd0, data_out}, {28'd0, e.d});
`ifdef RAM_PORT_PARITY_EN
        chk("perr", {31'd0, perr}, {31'd0, e.pe});
`endif
      end
    end
  end

  task automatic wait_not_busy();
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit r, input logic [7:0] a, input logic [3:0] d,
                       input logic [3:0] ed, input bit ep);
    wait_not_busy();
    rw = r; addr = a; data_in = d;
    sb.push_back('{r, ed, ep});
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
  endtask

  function automatic logic get_busy(input int w);
    return (w == 1) ? busy1 : busy15;
  endfunction

  function automatic logic get_odv(input int w);
    return (w == 1) ? odv1 : odv15;
  endfunction

  task automatic measure(input int w, input int lat);
    int nb, first, nodv;
    nb = 0; first = -1; nodv = 0;
    rw = 1'b0; addr = 8'h44; data_in = 4'h1;
    if (w == 1) ce1 = 1'b1; else ce15 = 1'b1;
    @(negedge clk);
    ce1 = 1'b0; ce15 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (get_busy(w)) nb++;
      if (get_odv(w)) begin
        nodv++;
        if (first < 0) first = k;
      end
      @(negedge clk);
    end
    chk($sformatf("lat%0d_busy_cycles", lat), nb, lat);
    chk($sformatf("lat%0d_odv_edge", lat), first, lat);
    chk($sformatf("lat%0d_odv_count", lat), nodv, 1);
    chk($sformatf("lat%0d_dout_hold", lat), {28'd0, (w == 1) ? do1 : do15}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 8'h80, 4'h3, 4'h0};
    vecs[1]  = '{0, 8'h81, 4'h9, 4'h0};
    vecs[2]  = '{1, 8'h80, 4'h0, 4'h3};
    vecs[3]  = '{1, 8'h81, 4'h0, 4'h9};
    vecs[4]  = '{0, 8'h80, 4'hE, 4'h0};
    vecs[5]  = '{1, 8'h80, 4'h0, 4'hE};
    vecs[6]  = '{1, 8'hFF, 4'h0, 4'h0};
    vecs[7]  = '{0, 8'hFF, 4'hF, 4'h0};
    vecs[8]  = '{1, 8'hFF, 4'h0, 4'hF};
    vecs[9]  = '{1, 8'h01, 4'h0, 4'hC};
    vecs[10] = '{1, 8'h02, 4'h0, 4'h0};
    vecs[11] = '{1, 8'h3F, 4'h0, 4'h0};

    // Power-on reset
    #1;
    chk("rst_data_out", {28'd0, data_out}, 32'd0);
    chk("rst_odv", {31'd0, odv}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // Write 0x5 to 0x3F, then read it back presented during the odv cycle
    rw = 1'b0; addr = 8'h3F; data_in = 4'h5; ce = 1'b1;
    sb.push_back('{0, 4'h0, 0});
    @(negedge clk); ce = 1'b0;
    chk("wr_busy_e0", {31'd0, busy}, 32'd1);
    chk("wr_odv_e0", {31'd0, odv}, 32'd0);
    @(negedge clk);
    chk("wr_busy_e1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("wr_odv_e2", {31'd0, odv}, 32'd1);
    chk("wr_busy_e2", {31'd0, busy}, 32'd0);
    rw = 1'b1; ce = 1'b1;
    sb.push_back('{1, 4'h5, 0});
    @(negedge clk); ce = 1'b0;
    chk("rd_busy_e3", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("rd_odv_e4", {31'd0, odv}, 32'd0);
    @(negedge clk);
    chk("rd_odv_e5", {31'd0, odv}, 32'd1);
    chk("rd_data_e5", {28'd0, data_out}, 32'h5);

    // Reset mid-BUSY of a write to 0x10
    rw = 1'b0; addr = 8'h10; data_in = 4'hA; ce = 1'b1;
    @(negedge clk); ce = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 clr = 1'b1;
    #1;
    sb.delete();
    chk("clr_data_out", {28'd0, data_out}, 32'd0);
    chk("clr_odv", {31'd0, odv}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("clr_hold_busy", {31'd0, busy}, 32'd0);
    chk("clr_hold_odv", {31'd0, odv}, 32'd0);
    @(negedge clk); clr = 1'b0;
    issue(1, 8'h10, 4'h0, 4'h0, 0);
    issue(1, 8'h3F, 4'h0, 4'h0, 0);

    // Back-to-back: read presented in the write's odv cycle
    issue(0, 8'h01, 4'hC, 4'h0, 0);
    for (int i = 0; i < 20 && !odv; i++) @(negedge clk);
    chk("b2b_odv_seen", {31'd0, odv}, 32'd1);
    rw = 1'b1; addr = 8'h01; ce = 1'b1;
    sb.push_back('{1, 4'hC, 0});
    @(negedge clk); ce = 1'b0;
    chk("b2b_accept", {31'd0, busy}, 32'd1);

    // ce pulsed while busy must be ignored
    issue(1, 8'h05, 4'h0, 4'h0, 0);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    rw = 1'b0; addr = 8'h02; data_in = 4'hF; ce = 1'b1;
    @(negedge clk); ce = 1'b0;
    issue(1, 8'h02, 4'h0, 4'h0, 0);

    // Vector table
    for (int i = 0; i < 12; i++)
      issue(vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].exp_d, 0);

`ifdef RAM_PORT_PARITY_EN
    pinj = 1'b1;
    issue(0, 8'h20, 4'h7, 4'h0, 0);
    pinj = 1'b0;
    issue(1, 8'h20, 4'h0, 4'h7, 1);
    issue(0, 8'h20, 4'h7, 4'h0, 0);
    issue(1, 8'h20, 4'h0, 4'h7, 0);
`endif

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    repeat (3) @(negedge clk);

    // Latency sweep on the extreme instances
    measure(1, 1);
    measure(15, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
